// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared constants for the ID-stage hazard/stall controller.
//   REG_ZERO   : architectural x0, never a real dependency
//   REG_ADDR_W : register address width
//   MC_LATENCY_DEFAULT : default number of cycles a multi-cycle op holds EX
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int MC_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/mc_busy_counter.sv
// mc_busy_counter
//   Down-counter tracking how long a non-pipelined multi-cycle op still
//   occupies EX. Loads MC_LATENCY-1 on issue so that the final EX cycle of
//   the op already reads as not busy and the pipeline advances in it.
//   Ports:
//     clk_i  : clock
//     rst_i  : synchronous active-high reset, aborts any hold in progress
//     issue  : a multi-cycle op leaves ID this cycle
//     busy   : multi-cycle op is still holding EX
module mc_busy_counter
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = MC_LATENCY_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue,
  output logic busy
);

  // At least one bit so MC_LATENCY=1 still yields a legal (always-zero) counter
  localparam int CW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MC_LATENCY - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (issue) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall.sv
// hazard_stall
//   ID-stage hazard and stall controller. Covers the hazards forwarding
//   cannot resolve (load-use, multi-cycle EX op), gates the branch flush of
//   IF/ID and counts stall cycles with a saturating counter.
//   Ports:
//     clk_i, rst_i          : clock, synchronous active-high reset
//     ID_*                  : instruction currently in ID
//     EX_MemRead_i/RDaddr_i : load in EX and its destination
//     PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o : pipeline reg enables
//     NoOp_o                : ID/EX loads a bubble (load-use)
//     EXMEM_Bubble_o        : EX/MEM loads a bubble while EX is held
//     Busy_o                : multi-cycle op holding EX
//     Stall_cnt_o           : saturating count of stall cycles since reset
module hazard_stall
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = MC_LATENCY_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ID_valid_i,
  input  logic [REG_ADDR_W-1:0] ID_RSaddr1_i,
  input  logic [REG_ADDR_W-1:0] ID_RSaddr2_i,
  input  logic                  ID_RS2used_i,
  input  logic                  ID_MC_i,
  input  logic                  ID_Branch_i,
  input  logic                  EX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] EX_RDaddr_i,
  output logic                  PCWrite_o,
  output logic                  IFID_Write_o,
  output logic                  IFID_Flush_o,
  output logic                  IDEX_Write_o,
  output logic                  NoOp_o,
  output logic                  EXMEM_Bubble_o,
  output logic                  Busy_o,
  output logic [CNT_W-1:0]      Stall_cnt_o
);

  logic lu;
  logic issue;
  logic busy;

  // x0 is never a real producer; rs2 only matters if the instruction reads it
  assign lu = ID_valid_i & EX_MemRead_i & (EX_RDaddr_i != REG_ZERO) &
              ((EX_RDaddr_i == ID_RSaddr1_i) |
               (ID_RS2used_i & (EX_RDaddr_i == ID_RSaddr2_i)));

  // A load-use dependent MC op waits for the bubble before it may issue
  assign issue = ID_valid_i & ID_MC_i & ~busy & ~lu;

  mc_busy_counter #(
    .MC_LATENCY(MC_LATENCY)
  ) u_mc_busy (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .issue (issue),
    .busy  (busy)
  );

  assign Busy_o = busy;

  // Busy outranks load-use; branch flush only when nothing is stalled
  always_comb begin
    PCWrite_o      = 1'b1;
    IFID_Write_o   = 1'b1;
    IDEX_Write_o   = 1'b1;
    NoOp_o         = 1'b0;
    EXMEM_Bubble_o = 1'b0;
    IFID_Flush_o   = 1'b0;
    if (busy) begin
      PCWrite_o      = 1'b0;
      IFID_Write_o   = 1'b0;
      IDEX_Write_o   = 1'b0;
      EXMEM_Bubble_o = 1'b1;
    end else if (lu) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      NoOp_o       = 1'b1;
    end else begin
      IFID_Flush_o = ID_Branch_i;
    end
  end

  // Saturating performance counter of stalled cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      Stall_cnt_o <= '0;
    end else if ((busy | lu) && (Stall_cnt_o != {CNT_W{1'b1}})) begin
      Stall_cnt_o <= Stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall.sv
// tb_hazard_stall
//   Scenario-driven bench for hazard_stall (MC_LATENCY=4, CNT_W=2 so that
//   counter saturation is reachable). Expected control vectors are queued
//   when stimulus is driven and compared on the following falling edge.
module tb_hazard_stall;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs2used;
  logic       id_mc;
  logic       id_branch;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       pc_write, ifid_write, ifid_flush, idex_write, noop, exmem_bubble, busy;
  logic [1:0] stall_cnt;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs2used;
    logic       mc;
    logic       branch;
    logic       memread;
    logic [4:0] rd;
  } stim_t;

  typedef struct {
    logic [6:0] ctrl;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, NoOp, EXMEM_Bubble, Busy}
  localparam logic [6:0] NORM  = 7'b1101000;
  localparam logic [6:0] FLUSH = 7'b1111000;
  localparam logic [6:0] LU    = 7'b0001100;
  localparam logic [6:0] BUSY  = 7'b0000011;

  always #5 clk = ~clk;

  hazard_stall #(
    .MC_LATENCY(4),
    .CNT_W(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ID_valid_i     (id_valid),
    .ID_RSaddr1_i   (id_rs1),
    .ID_RSaddr2_i   (id_rs2),
    .ID_RS2used_i   (id_rs2used),
    .ID_MC_i        (id_mc),
    .ID_Branch_i    (id_branch),
    .EX_MemRead_i   (ex_memread),
    .EX_RDaddr_i    (ex_rd),
    .PCWrite_o      (pc_write),
    .IFID_Write_o   (ifid_write),
    .IFID_Flush_o   (ifid_flush),
    .IDEX_Write_o   (idex_write),
    .NoOp_o         (noop),
    .EXMEM_Bubble_o (exmem_bubble),
    .Busy_o         (busy),
    .Stall_cnt_o    (stall_cnt)
  );

  assign obs = {pc_write, ifid_write, ifid_flush, idex_write, noop, exmem_bubble, busy};

  function automatic stim_t st(input logic r, input logic v, input logic [4:0] a1,
                               input logic [4:0] a2, input logic u2, input logic m,
                               input logic b, input logic mr, input logic [4:0] d);
    stim_t s;
    s = '{rst: r, valid: v, rs1: a1, rs2: a2, rs2used: u2, mc: m, branch: b,
          memread: mr, rd: d};
    return s;
  endfunction

  function automatic exp_t ex(input logic [6:0] c, input logic [1:0] n);
    exp_t e;
    e.ctrl = c;
    e.cnt  = n;
    return e;
  endfunction

  // Drives one cycle worth of inputs
  task automatic apply_stimulus(input stim_t s);
    rst        = s.rst;
    id_valid   = s.valid;
    id_rs1     = s.rs1;
    id_rs2     = s.rs2;
    id_rs2used = s.rs2used;
    id_mc      = s.mc;
    id_branch  = s.branch;
    ex_memread = s.memread;
    ex_rd      = s.rd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    apply_stimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply_stimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    sb.push_back(ex(NORM, 2'd0));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL reset: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
               obs, stall_cnt, e.ctrl, e.cnt);
    end
  endtask

  task automatic test_load_use();
    stim_t s[2] = '{st(0, 1, 5, 0, 0, 0, 0, 1, 5), st(0, 1, 5, 0, 0, 0, 0, 0, 5)};
    exp_t  x[2] = '{ex(LU, 2'd0), ex(NORM, 2'd1)};
    exp_t  e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply_stimulus(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL load_use[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, obs, stall_cnt, e.ctrl, e.cnt);
      end
    end
  endtask

  task automatic test_zero_and_rs2();
    stim_t s[4] = '{st(0, 1, 0, 0, 0, 0, 0, 1, 0), st(0, 1, 3, 7, 0, 0, 0, 1, 7),
                    st(0, 1, 3, 7, 1, 0, 0, 1, 7), st(0, 0, 3, 7, 1, 0, 0, 1, 7)};
    exp_t  x[4] = '{ex(NORM, 2'd0), ex(NORM, 2'd0), ex(LU, 2'd0), ex(NORM, 2'd1)};
    exp_t  e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      apply_stimulus(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL zero_rs2[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, obs, stall_cnt, e.ctrl, e.cnt);
      end
    end
  endtask

  task automatic test_mc_hold();
    stim_t idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stim_t s[6] = '{st(0, 1, 1, 2, 0, 1, 0, 0, 0), idle, idle, idle, idle, idle};
    exp_t  x[6] = '{ex(NORM, 2'd0), ex(BUSY, 2'd0), ex(BUSY, 2'd1), ex(BUSY, 2'd2),
                    ex(NORM, 2'd3), ex(NORM, 2'd3)};
    exp_t  e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply_stimulus(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL mc_hold[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, obs, stall_cnt, e.ctrl, e.cnt);
      end
    end
  endtask

  task automatic test_branch_stall();
    stim_t br = st(0, 1, 1, 2, 0, 0, 1, 0, 0);
    stim_t s[6] = '{st(0, 1, 1, 2, 0, 1, 0, 0, 0), br, br, br, br,
                    st(0, 1, 1, 2, 0, 0, 0, 0, 0)};
    exp_t  x[6] = '{ex(NORM, 2'd0), ex(BUSY, 2'd0), ex(BUSY, 2'd1), ex(BUSY, 2'd2),
                    ex(FLUSH, 2'd3), ex(NORM, 2'd3)};
    exp_t  e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply_stimulus(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL branch_stall[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, obs, stall_cnt, e.ctrl, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    stim_t idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stim_t s[5] = '{st(0, 1, 1, 2, 0, 1, 0, 0, 0), idle,
                    st(1, 0, 0, 0, 0, 0, 0, 0, 0), idle, idle};
    exp_t  x[5] = '{ex(NORM, 2'd0), ex(BUSY, 2'd0), ex(BUSY, 2'd1), ex(NORM, 2'd0),
                    ex(NORM, 2'd0)};
    exp_t  e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply_stimulus(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL reset_mid_op[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, obs, stall_cnt, e.ctrl, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t mc   = st(0, 1, 1, 2, 0, 1, 0, 0, 0);
    stim_t idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stim_t s[9] = '{mc, mc, mc, mc, mc, idle, idle, idle, idle};
    exp_t  x[9] = '{ex(NORM, 2'd0), ex(BUSY, 2'd0), ex(BUSY, 2'd1), ex(BUSY, 2'd2),
                    ex(NORM, 2'd3), ex(BUSY, 2'd3), ex(BUSY, 2'd3), ex(BUSY, 2'd3),
                    ex(NORM, 2'd3)};
    exp_t  e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      apply_stimulus(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, obs, stall_cnt, e.ctrl, e.cnt);
      end
    end
  endtask

  task automatic test_lu_then_mc();
    stim_t idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stim_t s[6] = '{st(0, 1, 5, 0, 0, 1, 0, 1, 5), st(0, 1, 5, 0, 0, 1, 0, 0, 5),
                    idle, idle, idle, idle};
    exp_t  x[6] = '{ex(LU, 2'd0), ex(NORM, 2'd1), ex(BUSY, 2'd1), ex(BUSY, 2'd2),
                    ex(BUSY, 2'd3), ex(NORM, 2'd3)};
    exp_t  e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply_stimulus(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL lu_then_mc[%0d]: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, obs, stall_cnt, e.ctrl, e.cnt);
      end
    end
  endtask

  initial begin
    apply_stimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("[TB] starting hazard_stall scenarios");
    test_reset();
    test_load_use();
    test_zero_and_rs2();
    test_mc_hold();
    test_branch_stall();
    test_reset_mid_op();
    test_back_to_back();
    test_lu_then_mc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall.md
# hazard_stall

ID-stage hazard and stall controller for the 5-stage pipeline, driving the pipeline registers from the producer side. The forwarding unit resolves operands once a result exists. This block covers the cases where no result exists yet:
- a load-use dependency, which costs one bubble;
- a non-pipelined multi-cycle EX operation (MUL/DIV), which holds EX for MC_LATENCY cycles.

It also gates the branch flush of IF/ID and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX (≥1)
- CNT_W, 16, width of stall counter
- clk_i  input  1  clock
- rst_i  input  1  reset; synchronous, active-high
- ID_valid_i  input  1  ID holds a real instruction
- ID_RSaddr1_i  input  5  rs1 of ID instruction
- ID_RSaddr2_i  input  5  rs2 of ID instruction
- ID_RS2used_i  input  1  ID instruction reads rs2
- ID_MC_i  input  1  ID instruction is multi-cycle
- ID_Branch_i  input  1  branch in ID resolved taken
- EX_MemRead_i  input  1  instruction in EX is a load
- EX_RDaddr_i  input  5  rd of EX instruction
- PCWrite_o  output  1  PC may update
- IFID_Write_o  output  1  IF/ID may load
- IFID_Flush_o  output  1  IF/ID loads a NOP
- IDEX_Write_o  output  1  ID/EX may load (0 = hold)
- NoOp_o  output  1  ID/EX loads a bubble
- EXMEM_Bubble_o  output  1  EX/MEM loads a bubble
- Busy_o  output  1  multi-cycle op holding EX
- Stall_cnt_o  output  CNT_W  stall cycles since reset

## Operation
**Multi-cycle counter.**
- State is a down-counter `cnt`. `Busy_o = (cnt != 0)`.
- issue = ID_valid_i & ID_MC_i & !Busy_o & !lu.
- On issue, `cnt` loads MC_LATENCY-1.
- Otherwise, if `cnt != 0`, it decrements.
- With MC_LATENCY=1, `Busy_o` never asserts.

**Load-use.**
- lu = ID_valid_i & EX_MemRead_i & (EX_RDaddr_i != 0) & ((EX_RDaddr_i == ID_RSaddr1_i) | (ID_RS2used_i & EX_RDaddr_i == ID_RSaddr2_i)).

**Output priority (combinational from `cnt` and inputs).**
- Busy_o=1: PCWrite=0, IFID_Write=0, IDEX_Write=0, NoOp=0, EXMEM_Bubble=1, IFID_Flush=0.
- Else lu=1: PCWrite=0, IFID_Write=0, IDEX_Write=1, NoOp=1, EXMEM_Bubble=0, IFID_Flush=0.
- Else: all Write=1, NoOp=0, EXMEM_Bubble=0, IFID_Flush=ID_Branch_i.

**Hazard interactions.**
- A branch is never flushed while stalled. It is re-evaluated once the stall clears.
- When busy, EX holds the MC op, which is never a load, so lu and busy are mutually exclusive in practice. Busy still has priority.
- An MC op in ID that is itself load-use dependent is not issued until the cycle after the bubble.

**Stall counter.**
- Stall_cnt_o increments by 1 on each cycle where Busy_o | lu.
- It saturates at all-ones.

## Timing
**Reset.**
- rst_i high at an edge sets cnt=0 and Stall_cnt_o=0.
- Busy_o=0 from the cycle after.
- Reset mid-MC-op aborts the hold immediately: the next cycle shows PCWrite_o=1 (absent lu).

**MC op cycle numbering.**
- The MC op is issued at edge E0. It sits in EX during cycles 1..MC_LATENCY.
- Cycles 1..MC_LATENCY-1 have Busy_o=1.
- Cycle MC_LATENCY has Busy_o=0 and the pipeline advances.
- Total front-end stall is MC_LATENCY-1 cycles.

**Load-use and latency.**
- Load-use costs exactly one cycle of NoOp_o=1. The next cycle re-evaluates with the bubble in EX, so lu=0.
- All outputs except the counters are same-cycle combinational; there is no registered latency.

**Back-to-back MC ops.**
- A second MC op sitting in ID issues in cycle MC_LATENCY, when Busy_o=0.
- `cnt` reloads with no idle gap.

## Structure
- Shared package `hazard_pkg`: REG_ZERO (5'd0), REG_ADDR_W (5), MC_LATENCY default.
- One natural sub-module, `mc_busy_counter`:
  - holds `cnt` and exposes `busy`;
  - inputs: clk_i, rst_i, issue;
  - parameter MC_LATENCY.
- Priority mux and stall counter live in the top.

## Test plan
- **Load-use:** EX_MemRead_i=1, EX_RDaddr_i=5, ID_RSaddr1_i=5, ID_valid_i=1 -> one cycle PCWrite_o=0, IFID_Write_o=0, NoOp_o=1. Next cycle (EX_MemRead_i=0) all Write=1, Stall_cnt_o=1.
- **rd=x0 / unused rs2:** EX_RDaddr_i=0 matching rs1 -> no stall. rs2 match with ID_RS2used_i=0 -> no stall.
- **MC hold:** MC_LATENCY=4, MC op in ID -> Busy_o=1 for exactly 3 cycles with IDEX_Write_o=0, EXMEM_Bubble_o=1, then released. Stall_cnt_o=3.
- **Branch during stall:** ID_Branch_i=1 held while Busy_o=1 -> IFID_Flush_o=0 until Busy_o drops, then 1 for that cycle.
- **Reset mid-op:** rst_i pulsed in 2nd busy cycle -> Busy_o=0, Stall_cnt_o=0, PCWrite_o=1 the following cycle.
- **Back-to-back MC ops plus saturation:** two consecutive MC ops, MC_LATENCY=4 -> 6 busy cycles with one advance cycle between the two holds. With CNT_W=2, Stall_cnt_o sticks at 3.
